// File: rtl/coef_load_ctrl.sv
// coef_load_ctrl: streams 40 coefficients into the 4-bank x 10-tap FIR coefficient SRAMs
module coef_load_ctrl #(
   parameter int COEF_W   = 16,
   parameter int NUM_TAP  = 10,
   parameter int NUM_BANK = 4
) (
   input  logic              iClk_12M,
   input  logic              iRst,
   input  logic              iUpdateFlag,
   input  logic              iCoefValid,
   input  logic [COEF_W-1:0] iCoefData,
   output logic              oCoefReady,
   output logic              oCsn_Upd_1,
   output logic              oCsn_Upd_2,
   output logic              oCsn_Upd_3,
   output logic              oCsn_Upd_4,
   output logic              oWrn_Upd_1,
   output logic              oWrn_Upd_2,
   output logic              oWrn_Upd_3,
   output logic              oWrn_Upd_4,
   output logic [3:0]        oAddr_Upd,
   output logic [COEF_W-1:0] oWrDt_Upd,
   output logic [5:0]        oWrCnt,
   output logic              oUpdDone,
   output logic              oErrShort,
   output logic              oErrExtra
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   state_t            r_state, w_next;
   logic [1:0]        r_bank;
   logic [3:0]        r_tap;
   logic [3:0]        r_we;
   logic [3:0]        r_addr;
   logic [COEF_W-1:0] r_data;
   logic [5:0]        r_cnt;
   logic              r_done, r_err_short, r_err_extra;
   logic              w_accept, w_start, w_last;
   assign w_last = (r_bank == 2'(NUM_BANK-1)) && (r_tap == 4'(NUM_TAP-1));
   // next state, ready and beat acceptance; a beat offered while the window closes is refused
   always_comb begin
      w_next     = r_state;
      oCoefReady = 1'b0;
      w_accept   = 1'b0;
      w_start    = 1'b0;
      case (r_state)
         IDLE: if (iUpdateFlag) begin
            w_next  = LOAD;
            w_start = 1'b1;
         end
         LOAD: begin
            oCoefReady = 1'b1;
            if (!iUpdateFlag) w_next = IDLE;
            else if (iCoefValid) begin
               w_accept = 1'b1;
               if (w_last) w_next = DONE;
            end
         end
         DONE: if (!iUpdateFlag) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge iClk_12M or posedge iRst)
      if (iRst) r_state <= IDLE;
      else r_state <= w_next;
   // counters, one-cycle write strobe and sticky status flags
   always_ff @(posedge iClk_12M or posedge iRst)
      if (iRst) begin
         r_bank      <= '0;
         r_tap       <= '0;
         r_we        <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_err_short <= 1'b0;
         r_err_extra <= 1'b0;
      end else begin
         r_we <= '0;
         if (w_start) begin
            r_bank      <= '0;
            r_tap       <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_err_short <= 1'b0;
            r_err_extra <= 1'b0;
         end
         if (w_accept) begin
            r_we   <= 4'b0001 << r_bank;
            r_addr <= r_tap;
            r_data <= iCoefData;
            r_cnt  <= (r_cnt == 6'(NUM_TAP*NUM_BANK)) ? r_cnt : r_cnt + 6'd1;
            r_done <= w_last;
            if (!w_last) begin
               r_tap  <= (r_tap == 4'(NUM_TAP-1)) ? 4'd0 : r_tap + 4'd1;
               r_bank <= (r_tap == 4'(NUM_TAP-1)) ? r_bank + 2'd1 : r_bank;
            end
         end
         if (r_state == LOAD && !iUpdateFlag) r_err_short <= 1'b1;
         if (r_state == DONE && iCoefValid) r_err_extra <= 1'b1;
      end
   assign {oCsn_Upd_4, oCsn_Upd_3, oCsn_Upd_2, oCsn_Upd_1} = ~r_we;
   assign {oWrn_Upd_4, oWrn_Upd_3, oWrn_Upd_2, oWrn_Upd_1} = ~r_we;
   assign oAddr_Upd = r_addr;
   assign oWrDt_Upd = r_data;
   assign oWrCnt    = r_cnt;
   assign oUpdDone  = r_done;
   assign oErrShort = r_err_short;
   assign oErrExtra = r_err_extra;
endmodule

// File: tb/tb_coef_load_ctrl.sv
// tb_coef_load_ctrl: directed scoreboard bench for coef_load_ctrl
module tb_coef_load_ctrl;
   logic        clk = 1'b0;
   logic        iRst, iUpdateFlag, iCoefValid;
   logic [15:0] iCoefData;
   logic        oCoefReady;
   logic        oCsn_Upd_1, oCsn_Upd_2, oCsn_Upd_3, oCsn_Upd_4;
   logic        oWrn_Upd_1, oWrn_Upd_2, oWrn_Upd_3, oWrn_Upd_4;
   logic [3:0]  oAddr_Upd;
   logic [15:0] oWrDt_Upd;
   logic [5:0]  oWrCnt;
   logic        oUpdDone, oErrShort, oErrExtra;
   int          n_pass = 0, n_total = 0, k = 0;
   logic [21:0] q[$];
   logic [21:0] m_exp;
   logic [3:0]  m_w;
   logic [1:0]  m_bank;

   coef_load_ctrl dut (
      .iClk_12M(clk), .iRst(iRst), .iUpdateFlag(iUpdateFlag), .iCoefValid(iCoefValid),
      .iCoefData(iCoefData), .oCoefReady(oCoefReady),
      .oCsn_Upd_1(oCsn_Upd_1), .oCsn_Upd_2(oCsn_Upd_2), .oCsn_Upd_3(oCsn_Upd_3), .oCsn_Upd_4(oCsn_Upd_4),
      .oWrn_Upd_1(oWrn_Upd_1), .oWrn_Upd_2(oWrn_Upd_2), .oWrn_Upd_3(oWrn_Upd_3), .oWrn_Upd_4(oWrn_Upd_4),
      .oAddr_Upd(oAddr_Upd), .oWrDt_Upd(oWrDt_Upd), .oWrCnt(oWrCnt),
      .oUpdDone(oUpdDone), .oErrShort(oErrShort), .oErrExtra(oErrExtra)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] d, input bit push);
      iCoefValid = 1'b1;
      iCoefData  = d;
      if (push) begin
         q.push_back({2'(k / 10), 4'(k % 10), d});
         k++;
      end
      step();
   endtask

   // write monitor: every strobe must be one-hot, Wrn must track Csn, and match the next expected write
   always @(negedge clk) begin
      m_w = ~{oCsn_Upd_4, oCsn_Upd_3, oCsn_Upd_2, oCsn_Upd_1};
      if (m_w != 4'd0) begin
         chk("strobe_onehot", $countones(m_w), 32'd1);
         chk("wrn_eq_csn", 32'({oWrn_Upd_4, oWrn_Upd_3, oWrn_Upd_2, oWrn_Upd_1}),
             32'({oCsn_Upd_4, oCsn_Upd_3, oCsn_Upd_2, oCsn_Upd_1}));
         m_bank = m_w[1] ? 2'd1 : m_w[2] ? 2'd2 : m_w[3] ? 2'd3 : 2'd0;
         if (q.size() == 0) chk("unexpected_write", 32'(m_w), 32'd0);
         else begin
            m_exp = q.pop_front();
            chk("write_bank_addr_data", 32'({m_bank, oAddr_Upd, oWrDt_Upd}), 32'(m_exp));
         end
      end
   end

   initial begin
      iRst = 1'b0; iUpdateFlag = 1'b0; iCoefValid = 1'b0; iCoefData = '0;
      #1 iRst = 1'b1;
      #2;
      chk("rst_csn", 32'({oCsn_Upd_4, oCsn_Upd_3, oCsn_Upd_2, oCsn_Upd_1}), 32'hF);
      chk("rst_wrn", 32'({oWrn_Upd_4, oWrn_Upd_3, oWrn_Upd_2, oWrn_Upd_1}), 32'hF);
      chk("rst_addr_data", 32'({oAddr_Upd, oWrDt_Upd}), 32'd0);
      chk("rst_status", 32'({oWrCnt, oCoefReady, oUpdDone, oErrShort, oErrExtra}), 32'd0);
      step();
      iRst = 1'b0;
      step();
      // full load, back to back
      iUpdateFlag = 1'b1;
      step();
      chk("t1_ready_in_load", 32'(oCoefReady), 32'd1);
      for (int i = 0; i < 40; i++) beat(16'h0100 + 16'(i), 1'b1);
      iCoefValid = 1'b0;
      step();
      chk("t1_done", 32'(oUpdDone), 32'd1);
      chk("t1_wrcnt", 32'(oWrCnt), 32'd40);
      chk("t1_queue_drained", 32'(q.size()), 32'd0);
      chk("t1_last_addr", 32'(oAddr_Upd), 32'd9);
      // extra beat in DONE
      beat(16'hDEAD, 1'b0);
      iCoefValid = 1'b0;
      chk("t4_err_extra", 32'(oErrExtra), 32'd1);
      chk("t4_ready_done", 32'(oCoefReady), 32'd0);
      chk("t4_wrcnt_sat", 32'(oWrCnt), 32'd40);
      step();
      chk("t4_no_extra_write", 32'(q.size()), 32'd0);
      iUpdateFlag = 1'b0;
      step();
      chk("t4_done_held_idle", 32'(oUpdDone), 32'd1);
      // reload window with gapped valid
      k = 0;
      iUpdateFlag = 1'b1;
      step();
      chk("t6_flags_cleared", 32'({oUpdDone, oErrShort, oErrExtra}), 32'd0);
      chk("t6_wrcnt_cleared", 32'(oWrCnt), 32'd0);
      for (int i = 0; i < 40; i++) begin
         beat(16'hA000 + 16'(i), 1'b1);
         iCoefValid = 1'b0;
         step();
         chk("t2_idle_csn", 32'({oCsn_Upd_4, oCsn_Upd_3, oCsn_Upd_2, oCsn_Upd_1}), 32'hF);
      end
      chk("t2_done", 32'(oUpdDone), 32'd1);
      chk("t2_wrcnt", 32'(oWrCnt), 32'd40);
      chk("t2_queue_drained", 32'(q.size()), 32'd0);
      iUpdateFlag = 1'b0;
      step();
      // early close after 17 beats, beat 17 offered in the drop cycle
      k = 0;
      iUpdateFlag = 1'b1;
      step();
      for (int i = 0; i < 17; i++) beat(16'h0300 + 16'(i), 1'b1);
      iUpdateFlag = 1'b0;
      iCoefData = 16'hBEEF;
      step();
      iCoefValid = 1'b0;
      step();
      chk("t3_err_short", 32'(oErrShort), 32'd1);
      chk("t3_not_done", 32'(oUpdDone), 32'd0);
      chk("t3_wrcnt", 32'(oWrCnt), 32'd17);
      chk("t3_last_addr", 32'(oAddr_Upd), 32'd6);
      chk("t3_last_data", 32'(oWrDt_Upd), 32'h0310);
      chk("t3_queue_drained", 32'(q.size()), 32'd0);
      // async reset mid-load while beat 24 is being written and beat 25 is offered
      k = 0;
      iUpdateFlag = 1'b1;
      step();
      chk("t5_err_short_cleared", 32'(oErrShort), 32'd0);
      for (int i = 0; i < 24; i++) beat(16'h0400 + 16'(i), 1'b1);
      beat(16'h0418, 1'b0);
      iCoefData = 16'h0419;
      #1 iRst = 1'b1;
      #1;
      chk("t5_rst_csn", 32'({oCsn_Upd_4, oCsn_Upd_3, oCsn_Upd_2, oCsn_Upd_1}), 32'hF);
      chk("t5_rst_addr_data", 32'({oAddr_Upd, oWrDt_Upd}), 32'd0);
      chk("t5_rst_status", 32'({oWrCnt, oCoefReady, oUpdDone, oErrShort, oErrExtra}), 32'd0);
      iUpdateFlag = 1'b0;
      iCoefValid = 1'b0;
      step();
      iRst = 1'b0;
      step();
      chk("t5_no_strobe_after_rst", 32'({oCsn_Upd_4, oCsn_Upd_3, oCsn_Upd_2, oCsn_Upd_1}), 32'hF);
      k = 0;
      iUpdateFlag = 1'b1;
      step();
      beat(16'h5555, 1'b1);
      iCoefValid = 1'b0;
      chk("t5_restart_bank1", 32'({oCsn_Upd_4, oCsn_Upd_3, oCsn_Upd_2, oCsn_Upd_1}), 32'hE);
      chk("t5_restart_addr", 32'(oAddr_Upd), 32'd0);
      step();
      chk("t5_wrcnt", 32'(oWrCnt), 32'd1);
      chk("t5_queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
